// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store, memory and finish/halt signals of mem_port_arbiter.
// slave = arbiter view, master = core/memory environment view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              if_req_i;
    logic [63:0]       if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;

    logic              ls_req_i;
    logic              ls_we_i;
    logic [63:0]       ls_addr_i;
    logic [31:0]       ls_wdata_i;
    logic [3:0]        ls_wstrb_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [31:0]       ls_rdata_o;

    logic              finish_i;
    logic              halted_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [3:0]        mem_wstrb_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wstrb_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  finish_i,
        output halted_o,
        output mem_addr_o, mem_we_o, mem_wstrb_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wstrb_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output finish_i,
        input  halted_o,
        input  mem_addr_o, mem_we_o, mem_wstrb_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one byte-addressed memory; writes a sentinel and halts on finish.
// Optional ARB_RR_EN macro: round-robin on contested cycles instead of ls priority with starvation override.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [7:0]  SENTINEL   = 8'hFF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    mem_port_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {ST_RUN, ST_SENTINEL, ST_HALT} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_starve;
    logic             r_if_rvalid;
    logic             r_ls_rvalid;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_ls_rdata;
    logic             r_halted;
`ifdef ARB_RR_EN
    logic             r_last_ls;
`endif

    logic w_run;
    logic w_if_win;
    logic w_if_gnt;
    logic w_ls_gnt;
    logic w_unused_addr_hi;

    assign w_run = (r_state == ST_RUN);

`ifdef ARB_RR_EN
    assign w_if_win = bus.if_req_i & (~bus.ls_req_i | r_last_ls);
`else
    assign w_if_win = bus.if_req_i & (~bus.ls_req_i | (r_starve == CNT_W'(STARVE_MAX)));
`endif

    assign w_if_gnt = w_run & w_if_win;
    assign w_ls_gnt = w_run & bus.ls_req_i & ~w_if_win;

    // Only the low ADDR_W address bits reach the memory, so addresses wrap.
    assign w_unused_addr_hi = ^{bus.if_addr_i[63:ADDR_W], bus.ls_addr_i[63:ADDR_W]};

    always_comb begin
        bus.mem_addr_o  = '0;
        bus.mem_we_o    = 1'b0;
        bus.mem_wstrb_o = 4'b0000;
        bus.mem_wdata_o = bus.ls_wdata_i;
        if (r_state == ST_SENTINEL) begin
            bus.mem_addr_o  = '1;
            bus.mem_we_o    = 1'b1;
            bus.mem_wstrb_o = 4'b0001;
            bus.mem_wdata_o = {24'h0, SENTINEL};
        end else if (w_if_gnt) begin
            bus.mem_addr_o  = bus.if_addr_i[ADDR_W-1:0];
        end else if (w_ls_gnt) begin
            bus.mem_addr_o  = bus.ls_addr_i[ADDR_W-1:0];
            bus.mem_we_o    = bus.ls_we_i;
            bus.mem_wstrb_o = bus.ls_we_i ? bus.ls_wstrb_i : 4'b0000;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_RUN;
            r_starve    <= '0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_halted    <= 1'b0;
`ifdef ARB_RR_EN
            r_last_ls   <= 1'b0;
`endif
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_ls_rvalid <= w_ls_gnt;
            if (w_if_gnt) begin
                r_if_rdata <= bus.mem_rdata_i;
            end
            if (w_ls_gnt && !bus.ls_we_i) begin
                r_ls_rdata <= bus.mem_rdata_i;
            end
`ifdef ARB_RR_EN
            r_starve <= '0;
            if (w_if_gnt) begin
                r_last_ls <= 1'b0;
            end else if (w_ls_gnt) begin
                r_last_ls <= 1'b1;
            end
`else
            if (!bus.if_req_i || w_if_gnt) begin
                r_starve <= '0;
            end else if (r_starve != CNT_W'(STARVE_MAX)) begin
                r_starve <= CNT_W'(r_starve + 1'b1);
            end
`endif
            case (r_state)
                ST_RUN: begin
                    if (bus.finish_i) begin
                        r_state <= ST_SENTINEL;
                    end
                end
                ST_SENTINEL: begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end
                ST_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign bus.if_gnt_o    = w_if_gnt;
    assign bus.ls_gnt_o    = w_ls_gnt;
    assign bus.if_rvalid_o = r_if_rvalid;
    assign bus.ls_rvalid_o = r_ls_rvalid;
    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.ls_rdata_o  = r_ls_rdata;
    assign bus.halted_o    = r_halted;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte memory environment plus a transaction-level reference model.
// Honours ARB_RR_EN when the build defines it.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned DEPTH      = 1 << ADDR_W;
    localparam int unsigned STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst_n;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .SENTINEL(8'hFF)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] env_mem [0:DEPTH-1];
    logic [7:0] ref_mem [0:DEPTH-1];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (bus.mem_we_o && bus.mem_wstrb_o[k])
                env_mem[(int'(bus.mem_addr_o) + k) % DEPTH] <= bus.mem_wdata_o[8*k +: 8];
    end

    always_comb begin
        bus.mem_rdata_i = '0;
        for (int k = 0; k < 4; k++)
            bus.mem_rdata_i[8*k +: 8] = env_mem[(int'(bus.mem_addr_o) + k) % DEPTH];
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_phase;     // 0 running, 1 writing sentinel, 2 halted
    int          m_denied;    // consecutive cycles fetch asked and lost
    bit          m_last_ls;
    bit          m_if_rv, m_ls_rv;
    logic [31:0] m_if_rd, m_ls_rd;

    // Combinational observations of the most recent step
    logic             g_if_gnt, g_ls_gnt, g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [3:0]       g_strb;
    logic [31:0]      g_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input int a);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_mem[(a + k) % DEPTH];
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_denied = 0; m_last_ls = 1'b0;
        m_if_rv = 1'b0; m_ls_rv = 1'b0; m_if_rd = '0; m_ls_rd = '0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_if_rvalid"}, 64'(bus.if_rvalid_o), 64'(m_if_rv));
        chk({tag, "_ls_rvalid"}, 64'(bus.ls_rvalid_o), 64'(m_ls_rv));
        chk({tag, "_if_rdata"},  64'(bus.if_rdata_o),  64'(m_if_rd));
        chk({tag, "_ls_rdata"},  64'(bus.ls_rdata_o),  64'(m_ls_rd));
        chk({tag, "_halted"},    64'(bus.halted_o),    64'(m_phase == 2));
    endtask

    task automatic idle_inputs();
        bus.if_req_i = 1'b0; bus.if_addr_i = '0;
        bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_addr_i = '0;
        bus.ls_wdata_i = '0; bus.ls_wstrb_i = '0; bus.finish_i = 1'b0;
    endtask

    // One clock: check grants/memory drive mid-cycle, then registered outputs after the edge.
    task automatic step();
        bit              e_if, e_ls, if_win, s_if_req, s_fin, s_rst;
        int              e_addr;
        logic            e_we;
        logic [3:0]      e_strb;
        logic [31:0]     e_wdata, rd_val;
        @(negedge clk);
        e_if = 0; e_ls = 0; e_addr = 0; e_we = 0; e_strb = 0; e_wdata = bus.ls_wdata_i;
        if (m_phase == 0) begin
`ifdef ARB_RR_EN
            if_win = bus.if_req_i && (!bus.ls_req_i || m_last_ls);
`else
            if_win = bus.if_req_i && (!bus.ls_req_i || m_denied >= STARVE_MAX);
`endif
            e_if = if_win;
            e_ls = bus.ls_req_i && !if_win;
            if (e_if) e_addr = int'(bus.if_addr_i % 64'(DEPTH));
            if (e_ls) begin
                e_addr = int'(bus.ls_addr_i % 64'(DEPTH));
                e_we   = bus.ls_we_i;
                e_strb = bus.ls_we_i ? bus.ls_wstrb_i : 4'b0000;
            end
        end else if (m_phase == 1) begin
            e_addr = DEPTH - 1; e_we = 1'b1; e_strb = 4'b0001; e_wdata = 32'h0000_00FF;
        end
        rd_val = ref_rd(e_addr);
        g_if_gnt = bus.if_gnt_o; g_ls_gnt = bus.ls_gnt_o; g_addr = bus.mem_addr_o;
        g_we = bus.mem_we_o; g_strb = bus.mem_wstrb_o; g_wdata = bus.mem_wdata_o;
        chk("if_gnt",    64'(g_if_gnt), 64'(e_if));
        chk("ls_gnt",    64'(g_ls_gnt), 64'(e_ls));
        chk("mem_addr",  64'(g_addr),   64'(e_addr));
        chk("mem_we",    64'(g_we),     64'(e_we));
        chk("mem_wstrb", 64'(g_strb),   64'(e_strb));
        if (e_we) chk("mem_wdata", 64'(g_wdata), 64'(e_wdata));
        s_if_req = bus.if_req_i; s_fin = bus.finish_i; s_rst = rst_n;
        @(posedge clk);
        #1;
        // Memory is written at the edge regardless of the arbiter reset.
        for (int k = 0; k < 4; k++)
            if (e_we && e_strb[k]) ref_mem[(e_addr + k) % DEPTH] = e_wdata[8*k +: 8];
        if (!s_rst) begin
            model_reset();
        end else begin
            m_if_rv = e_if; m_ls_rv = e_ls;
            if (e_if) m_if_rd = rd_val;
            if (e_ls && !e_we) m_ls_rd = rd_val;
            if (!s_if_req || e_if) m_denied = 0; else m_denied++;
            if (e_if) m_last_ls = 1'b0; else if (e_ls) m_last_ls = 1'b1;
            if (m_phase == 0 && s_fin) m_phase = 1;
            else if (m_phase == 1) m_phase = 2;
        end
        check_regs("post");
    endtask

    task automatic rand_inputs();
        bus.if_req_i   = ($urandom_range(0, 3) != 0);
        bus.if_addr_i  = {$urandom(), $urandom()};
        bus.ls_req_i   = ($urandom_range(0, 2) != 0);
        bus.ls_we_i    = $urandom_range(0, 1) == 1;
        bus.ls_addr_i  = {$urandom(), $urandom()};
        bus.ls_wdata_i = $urandom();
        bus.ls_wstrb_i = 4'($urandom());
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    int if_cnt;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = 8'($urandom());
            ref_mem[i] = env_mem[i];
        end
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_if_rvalid", 64'(bus.if_rvalid_o), 64'(0));
        chk("rst_ls_rvalid", 64'(bus.ls_rvalid_o), 64'(0));
        chk("rst_halted",    64'(bus.halted_o),    64'(0));
        chk("rst_if_rdata",  64'(bus.if_rdata_o),  64'(0));
        chk("rst_ls_rdata",  64'(bus.ls_rdata_o),  64'(0));
        rst_n = 1'b1;

        // Fetch only
        env_mem[16] = 8'h11; env_mem[17] = 8'h22; env_mem[18] = 8'h33; env_mem[19] = 8'h44;
        ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h33; ref_mem[19] = 8'h44;
        bus.if_req_i = 1'b1; bus.if_addr_i = 64'h10;
        step();
        chk("fetch_gnt",    64'(g_if_gnt),         64'(1));
        chk("fetch_rvalid", 64'(bus.if_rvalid_o),  64'(1));
        chk("fetch_rdata",  64'(bus.if_rdata_o),   64'h4433_2211);

        // Store then load
        idle_inputs();
        bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b1; bus.ls_addr_i = 64'h20;
        bus.ls_wdata_i = 32'hDEAD_BEEF; bus.ls_wstrb_i = 4'hF;
        step();
        chk("store_we",     64'(g_we),             64'(1));
        chk("store_ack",    64'(bus.ls_rvalid_o),  64'(1));
        bus.ls_we_i = 1'b0; bus.ls_wdata_i = '0;
        step();
        chk("load_rdata",   64'(bus.ls_rdata_o),   64'hDEAD_BEEF);

        // Continuous contention from reset
        do_reset();
        if_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            bus.if_req_i = 1'b1; bus.if_addr_i = 64'($urandom());
            bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b0; bus.ls_addr_i = 64'($urandom());
            step();
            if (g_if_gnt) if_cnt++;
        end
`ifdef ARB_RR_EN
        chk("contend_if_grants", 64'(if_cnt), 64'(7));
`else
        chk("contend_if_grants", 64'(if_cnt), 64'(3));
`endif

        // Address wrap
        idle_inputs();
        bus.if_req_i = 1'b1; bus.if_addr_i = 64'hFFFF_FFFF_0000_0404;
        step();
        chk("wrap_addr", 64'(g_addr), 64'h004);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            step();
        end

        // Finish during a load
        idle_inputs();
        bus.ls_req_i = 1'b1; bus.ls_addr_i = 64'h0000_0000_0000_0100; bus.finish_i = 1'b1;
        step();
        chk("fin_load_rvalid", 64'(bus.ls_rvalid_o), 64'(1));
        rand_inputs();
        bus.if_req_i = 1'b1; bus.ls_req_i = 1'b1; bus.finish_i = 1'b0;
        step();
        chk("sent_addr",  64'(g_addr),  64'h3FF);
        chk("sent_we",    64'(g_we),    64'(1));
        chk("sent_strb",  64'(g_strb),  64'b0001);
        chk("sent_wdata", 64'(g_wdata), 64'h0000_00FF);
        for (int i = 0; i < 6; i++) begin
            rand_inputs();
            bus.if_req_i = 1'b1; bus.finish_i = (i % 2) == 0;
            step();
            chk("halt_halted", 64'(bus.halted_o), 64'(1));
            chk("halt_no_gnt", 64'({g_if_gnt, g_ls_gnt}), 64'(0));
        end
        chk("sentinel_byte", 64'(env_mem[DEPTH-1]), 64'hFF);

        // Reset out of halt, then reset with a load in flight
        do_reset();
        chk("unhalt", 64'(bus.halted_o), 64'(0));
        idle_inputs();
        bus.ls_req_i = 1'b1; bus.ls_addr_i = 64'h44;
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_rvalid_dropped", 64'(bus.ls_rvalid_o), 64'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_inputs();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits between the core's instruction-fetch port and load/store port and the single shared byte-addressed test memory.
- The memory has a combinational 32-bit little-endian read (bytes addr..addr+3) and 4-lane byte-strobed write.
- Grants one requester per cycle and returns registered read data.
- On finish_i, takes ownership of the memory, writes a completion sentinel byte to the top address, then halts all traffic.

Parameters:
- ADDR_W, 10, memory byte-address width; depth is 2**ADDR_W bytes.
- STARVE_MAX, 4, consecutive denied cycles after which fetch wins a contested cycle.
- SENTINEL, 8'hFF, byte written to address 2**ADDR_W-1 on finish.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- if_req_i  in  1  fetch request.
- if_addr_i  in  64  fetch byte address.
- if_gnt_o  out  1  fetch granted this cycle.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  32  fetch read data.
- ls_req_i  in  1  load/store request.
- ls_we_i  in  1  1 = store.
- ls_addr_i  in  64  load/store byte address.
- ls_wdata_i  in  32  store data.
- ls_wstrb_i  in  4  store byte strobes; lane0 = byte at address.
- ls_gnt_o  out  1  load/store granted this cycle.
- ls_rvalid_o  out  1  load data valid, or store acknowledge.
- ls_rdata_o  out  32  load data.
- finish_i  in  1  program finished (level).
- mem_addr_o  out  ADDR_W  memory byte address.
- mem_we_o  out  1  memory write enable.
- mem_wstrb_o  out  4  memory byte strobes.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory combinational read data.
- halted_o  out  1  arbiter halted after sentinel write.

Behaviour:
- Reset values (rst_n_i low at an edge): state RUN; starvation counter 0; if_rvalid_o, ls_rvalid_o, halted_o = 0; if_rdata_o, ls_rdata_o = 0.
- Reset applies mid-operation from any state: any in-flight rvalid is dropped.
- States:
  - RUN: normal arbitration.
  - SENTINEL: one cycle, writes the sentinel byte.
  - HALT: terminal until reset.
- Grants (RUN only): if_gnt_o and ls_gnt_o are combinational in the request cycle; at most one is high.
  - Only one requester active: that requester is granted.
  - Both active: ls wins, unless the starvation counter equals STARVE_MAX, in which case if wins.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle if_req_i is high and not granted.
  - Clears on an if grant, or on any cycle if_req_i is low.
- Memory drive while granted:
  - mem_addr_o = granted addr[ADDR_W-1:0]; upper address bits are ignored, so addresses wrap modulo 2**ADDR_W.
  - mem_we_o = ls_we_i only when ls is granted, else 0.
  - mem_wstrb_o = ls_wstrb_i when ls is granted with ls_we_i = 1, else 4'b0000.
  - mem_wdata_o = ls_wdata_i.
  - No grant: mem_addr_o = 0, mem_we_o = 0, mem_wstrb_o = 0.
- Latency: 1 cycle.
  - The granted port's rvalid is high the cycle after the grant, with rdata = mem_rdata_i captured at the grant edge.
  - A store acks via ls_rvalid_o; ls_rdata_o holds its previous value.
  - rdata holds its value when rvalid is low.
- Back-to-back grants to the same port are allowed every cycle.
- Finish handling:
  - finish_i high in RUN: the current-cycle grant still proceeds normally and its rvalid still appears; next state SENTINEL.
  - SENTINEL: no grants; mem_addr_o = 2**ADDR_W-1, mem_we_o = 1, mem_wstrb_o = 4'b0001, mem_wdata_o = {24'h0, SENTINEL}; next state HALT.
  - HALT: halted_o = 1, no grants, memory outputs idle; finish_i is ignored.

Optional Feature:
- ARB_RR_EN defined: on contested cycles, the port not granted most recently wins (a last-grant bit, reset to favour ls).
  - The starvation counter and STARVE_MAX are unused; the counter stays 0.
- ARB_RR_EN undefined: fixed ls priority with starvation override, as above.

Test Plan:
- Fetch only: if_req_i=1, if_addr_i=0x10, mem bytes 0x10..0x13 = 11,22,33,44 -> if_gnt_o=1 same cycle; next cycle if_rvalid_o=1, if_rdata_o=0x44332211.
- Store then load: ls store 0xDEADBEEF, wstrb=4'hF to 0x20; next cycle load 0x20 -> mem_we_o=1 on the store cycle; load rdata=0xDEADBEEF one cycle after its grant.
- Both requesting continuously (fixed priority, STARVE_MAX=4) -> ls granted 4 cycles, if granted on the 5th, then the pattern repeats.
- Address wrap: if_addr_i=0xFFFF_FFFF_0000_0404 -> mem_addr_o=0x004.
- finish_i pulsed during an ls load -> the load's rvalid arrives; next cycle mem write addr 0x3FF, wstrb 4'b0001, wdata 0x000000FF; then halted_o=1 and all requests are ignored until rst_n_i is low for one edge.
- ARB_RR_EN: both requesting continuously -> grants alternate ls, if, ls, if.
